// File: rtl/wb_defs.sv
// Shared definitions for the two-master Wishbone arbiter: bus width defaults,
// grant encodings and the arbiter state encoding.
package wb_defs;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_SEL_WIDTH  = 4;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer timeout counter. expire_o is high in the cycle where the count
// reaches its terminal value with no ack; the arbiter registers it into ERR.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  input  logic ack_i,
  output logic expire_o
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      // An ack on the terminal cycle wins over the abort.
      always_comb begin
        expire_o = en_i & ~ack_i & ~clr_i & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        cnt_d    = cnt_q;
        if (clr_i | ack_i | expire_o) begin
          cnt_d = '0;
        end else if (en_i) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk_i, rst_ni, en_i, clr_i, ack_i};
      assign expire_o      = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter. Grant is held for a whole CYC and a
// watchdog aborts slave accesses that never ack.
module wb_arbiter
  import wb_defs::*;
#(
  parameter int WB_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int WB_ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WB_SEL_WIDTH   = DEF_SEL_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
  input  logic                     m0_we_i,
  input  logic                     m1_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
  input  logic                     m0_stb_i,
  input  logic                     m1_stb_i,
  input  logic                     m0_cyc_i,
  input  logic                     m1_cyc_i,
  output logic                     m0_ack_o,
  output logic                     m1_ack_o,
  output logic                     m0_err_o,
  output logic                     m1_err_o,
  output logic [WB_DATA_WIDTH-1:0] m0_data_o,
  output logic [WB_DATA_WIDTH-1:0] m1_data_o,
  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] s_data_o,
  output logic                     s_we_o,
  output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
  output logic                     s_stb_o,
  output logic                     s_cyc_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_data_i,
  output logic [1:0]               grant_o,
  output logic                     timeout_o
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic       timeout_q, timeout_d;
  logic       in_grant, holder_cyc, other_cyc;
  logic       wd_en, wd_clr, wd_expire;

  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    case (state_q)
      GRANT0: begin
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
      end
      GRANT1: begin
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
      end
      default: ;
    endcase
  end

  assign in_grant   = (state_q == GRANT0) || (state_q == GRANT1);
  assign holder_cyc = grant_q[0] ? m0_cyc_i : m1_cyc_i;
  assign other_cyc  = grant_q[0] ? m1_cyc_i : m0_cyc_i;
  assign wd_en      = in_grant & s_cyc_o & s_stb_o;
  assign wd_clr     = ~in_grant | ~s_cyc_o;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (wd_en),
    .clr_i   (wd_clr),
    .ack_i   (s_ack_i),
    .expire_o(wd_expire)
  );

  // Ties go to the master that did not hold the bus last.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = GRANT0;
          grant_d = GNT_M0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GRANT1;
          grant_d = GNT_M1;
          last_d  = 1'b1;
        end
      end
      default: begin
        if (!holder_cyc) begin
          if (other_cyc) begin
            state_d = grant_q[0] ? GRANT1 : GRANT0;
            grant_d = grant_q[0] ? GNT_M1 : GNT_M0;
            last_d  = grant_q[0];
          end else begin
            state_d = IDLE;
            grant_d = GNT_NONE;
          end
        end else if (wd_expire) begin
          state_d   = ABORT;
          timeout_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= GNT_NONE;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;
  assign m0_ack_o  = s_ack_i & grant_q[0];
  assign m1_ack_o  = s_ack_i & grant_q[1];
  assign m0_err_o  = timeout_q & grant_q[0];
  assign m1_err_o  = timeout_q & grant_q[1];
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master Wishbone arbiter placed between the bus masters and the SoC address decoder/mux slave port.
- Master 0 is the CPU. Master 1 is a second initiator (UART firmware loader / debug DMA) that needs RAM and peripheral access.
- Round-robin arbitration with grant held for a whole bus cycle (CYC high).
- Per-transfer watchdog terminates a hung slave access with ERR so neither master locks the bus.

Parameters:
- WB_DATA_WIDTH, 32, data bus width
- WB_ADDR_WIDTH, 32, address bus width
- WB_SEL_WIDTH, 4, byte-select width
- TIMEOUT_CYCLES, 255, cycles STB may wait for ACK before abort; 0 disables the watchdog

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- m0_addr_i, m1_addr_i  in  WB_ADDR_WIDTH  master address
- m0_data_i, m1_data_i  in  WB_DATA_WIDTH  master write data
- m0_we_i, m1_we_i  in  1  write enable
- m0_sel_i, m1_sel_i  in  WB_SEL_WIDTH  byte selects
- m0_stb_i, m1_stb_i  in  1  strobe
- m0_cyc_i, m1_cyc_i  in  1  cycle/request
- m0_ack_o, m1_ack_o  out  1  ack, gated by grant
- m0_err_o, m1_err_o  out  1  timeout error, gated by grant
- m0_data_o, m1_data_o  out  WB_DATA_WIDTH  read data (s_data_i broadcast)
- s_addr_o  out  WB_ADDR_WIDTH  to slave side
- s_data_o  out  WB_DATA_WIDTH  to slave side
- s_we_o  out  1  to slave side
- s_sel_o  out  WB_SEL_WIDTH  to slave side
- s_stb_o  out  1  to slave side
- s_cyc_o  out  1  to slave side
- s_ack_i  in  1  slave ack
- s_data_i  in  WB_DATA_WIDTH  slave read data
- grant_o  out  2  one-hot current grant; 00 means idle
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst_ni low):
  - state=IDLE, grant_o=00, last=1 (so M0 wins the first tie), counter=0.
  - s_cyc_o, s_stb_o, s_we_o, all ack/err outputs and timeout_o = 0.
  - Address, data and sel outputs = 0.
  - Reset asserted mid-transfer drops s_cyc_o immediately and needs no handshake.
- States and transitions:
  - IDLE: no cycle in progress. A master with cyc high is granted at the next clock edge (1-cycle arbitration latency), moving to GRANT0 or GRANT1.
  - GRANTn: slave outputs are combinationally muxed from master n, s_cyc_o=mn_cyc_i, s_stb_o=mn_stb_i. On the edge where mn_cyc_i is low, re-arbitrate from the current requests: go directly to the other GRANT if it is requesting (no dead cycle), else go to IDLE.
  - ABORT: s_cyc_o=s_stb_o=0 and grant_o keeps its value. Stays in ABORT until the granted master drops cyc, then re-arbitrates as above.
- Tie rule: simultaneous requests are granted to the master not equal to `last`. `last` updates on each new grant.
- A non-granted master sees ack=0 and err=0 and just keeps waiting. Its data_o equals s_data_i (harmless broadcast).
- Ack path: mn_ack_o = s_ack_i & grant[n], combinational, zero added latency. Back-to-back pipelined strobes within one CYC are passed through untouched.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter width is clog2(TIMEOUT_CYCLES+1). It increments each cycle in GRANTn with s_stb_o=1 and s_ack_i=0, and clears on ack, on cyc drop and on grant change.
  - When counter==TIMEOUT_CYCLES-1 and still no ack, the next cycle asserts mn_err_o=1 for exactly one cycle, asserts timeout_o=1 for one cycle, and enters ABORT.
  - If ack and the terminal count coincide, ack wins: no err and no abort.
- The counter never wraps; it saturates by construction because abort clears it.
- With TIMEOUT_CYCLES=0 the watchdog logic is constant-disabled and the ABORT state is unreachable.

Decomposition:
- Shared package/include wb_defs holds:
  - WB_DATA_WIDTH, WB_ADDR_WIDTH and WB_SEL_WIDTH defaults.
  - Grant encodings (GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10).
  - Arbiter state encoding (IDLE, GRANT0, GRANT1, ABORT).
- One sub-module, wb_arb_watchdog: the parameterised timeout counter. Inputs are enable/clear/ack; output is the expire pulse.

Test Plan:
- M0 single read, s_ack_i returned 2 cycles after stb -> grant_o=01 one cycle after m0_cyc_i; m0_ack_o high in the same cycle as s_ack_i; m0_data_o=s_data_i=32'hDEADBEEF.
- M0 and M1 raise cyc in the same cycle, three times back-to-back -> grants in order M0, M1, M0; each switch occurs on the edge after the holder drops cyc, with no IDLE cycle between.
- M1 holds cyc for 10 cycles with 3 strobes while M0 requests -> m0_ack_o stays 0 throughout, s_addr_o tracks m1_addr_i, and M0 is granted on the next edge after M1 releases.
- TIMEOUT_CYCLES=16, slave never acks an M0 write -> m0_err_o and timeout_o pulse exactly once, 16 cycles after stb; s_cyc_o=0 until m0_cyc_i drops; M1 is then grantable.
- Ack arrives on the exact terminal-count cycle -> m0_ack_o=1, m0_err_o=0, timeout_o=0.
- rst_ni pulled low asynchronously mid-M1 transfer -> s_cyc_o, s_stb_o and grant_o go to 0 before the next clock edge; after release, a tie is granted to M0.
